// File: rtl/exe_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline register and its skid buffer.
package exe_mem_pkg;

  localparam int EXE_MEM_DATA_W = 32;
  localparam int EXE_MEM_DEST_W = 4;

  typedef struct packed {
    logic                      wb_en;
    logic                      mem_r_en;
    logic                      mem_w_en;
    logic [EXE_MEM_DEST_W-1:0] dest;
    logic [EXE_MEM_DATA_W-1:0] val_rm;
    logic [EXE_MEM_DATA_W-1:0] alu_res;
  } exe_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry skid buffer: 'main' drives the outputs, 'skid' catches one extra entry
// so that in_ready_o can come straight from a flop.
module pipe_skid_buffer
  import exe_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             accept;
  logic             drain;

  assign accept      = in_valid_i & in_ready_q;
  assign drain       = (state_q != EMPTY) & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

  // in_ready_q tracks the next state, so it equals (state_q != FULL) except for the
  // single cycle after reset, where it is still held low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            main_q  <= in_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q     <= in_data_i;
            in_ready_q <= 1'b1;
          end else if (accept) begin
            skid_q     <= in_data_i;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EX->MEM pipeline register built on a 2-entry skid buffer, with NOP gating of the enables.
// Optional stall-cycle counter is built when EXE_MEM_STALL_CNT_EN is defined.
module exe_mem_pipe_reg
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_DATA_W,
  parameter int DEST_W = EXE_MEM_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DEST_W-1:0] Dest_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [DATA_W-1:0] ALU_res_in,
  input  logic              mem_ready,
  output logic              out_valid,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic [DEST_W-1:0] Dest_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [DATA_W-1:0] ALU_res_out
`ifdef EXE_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PAY_W = 3 + DEST_W + 2 * DATA_W;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic             wb_en_raw;
  logic             mem_r_en_raw;
  logic             mem_w_en_raw;

  // Field order matches exe_mem_payload_t so the flat bus can be viewed as that struct.
  assign pay_in = {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in, Val_Rm_in, ALU_res_in};

  pipe_skid_buffer #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (pay_in),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (mem_ready),
    .out_data_o  (pay_out)
  );

  assign {wb_en_raw, mem_r_en_raw, mem_w_en_raw, Dest_out, Val_Rm_out, ALU_res_out} = pay_out;

  // The memory stage must see a NOP when main is empty, while data keeps its last value.
  assign WB_EN_out    = wb_en_raw    & out_valid;
  assign MEM_R_EN_out = mem_r_en_raw & out_valid;
  assign MEM_W_EN_out = mem_w_en_raw & out_valid;

`ifdef EXE_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !mem_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  // Without the counter, stall cycles are simply not tracked.
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg: queue-based FIFO model plus directed and random stimulus.
module tb_exe_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [3:0]  Dest_in;
  logic [31:0] Val_Rm_in, ALU_res_in;
  logic        mem_ready;
  logic        out_valid;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
  logic [3:0]  Dest_out;
  logic [31:0] Val_Rm_out, ALU_res_out;
`ifdef EXE_MEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic        wr;
    logic [3:0]  dest;
    logic [31:0] val;
    logic [31:0] alu;
  } op_t;

  op_t         fifo[$];
  op_t         lastMain;
  bit          readyM;
  logic [31:0] stallM;

  always #5 clk = ~clk;

  exe_mem_pipe_reg dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .Dest_in      (Dest_in),
    .Val_Rm_in    (Val_Rm_in),
    .ALU_res_in   (ALU_res_in),
    .mem_ready    (mem_ready),
    .out_valid    (out_valid),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .MEM_W_EN_out (MEM_W_EN_out),
    .Dest_out     (Dest_out),
    .Val_Rm_out   (Val_Rm_out),
    .ALU_res_out  (ALU_res_out)
`ifdef EXE_MEM_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wb, input logic rd, input logic wr,
                               input logic [3:0] dest, input logic [31:0] val,
                               input logic [31:0] alu, input logic mr);
    in_valid    = v;
    WB_EN_in    = wb;
    MEM_R_EN_in = rd;
    MEM_W_EN_in = wr;
    Dest_in     = dest;
    Val_Rm_in   = val;
    ALU_res_in  = alu;
    mem_ready   = mr;
  endtask

  // Reference: a FIFO of at most two ops whose head is what the memory stage sees.
  task automatic modelStep();
    bit  acc;
    bit  drn;
    op_t op;
    if (rst) begin
      fifo.delete();
      lastMain = '0;
      readyM   = 1'b0;
      stallM   = '0;
    end else begin
      acc = in_valid && readyM;
      drn = (fifo.size() > 0) && mem_ready;
      if ((fifo.size() > 0) && !mem_ready && (stallM != 32'hFFFF_FFFF)) stallM++;
      if (drn) void'(fifo.pop_front());
      if (acc) begin
        op = '{wb: WB_EN_in, rd: MEM_R_EN_in, wr: MEM_W_EN_in,
               dest: Dest_in, val: Val_Rm_in, alu: ALU_res_in};
        fifo.push_back(op);
      end
      readyM = (fifo.size() < 2);
      if (fifo.size() > 0) lastMain = fifo[0];
    end
  endtask

  task automatic compareAll();
    bit  v;
    op_t h;
    v = (fifo.size() > 0);
    h = v ? fifo[0] : lastMain;
    checkOutput("in_ready", in_ready, readyM);
    checkOutput("out_valid", out_valid, v);
    checkOutput("WB_EN_out", WB_EN_out, v & h.wb);
    checkOutput("MEM_R_EN_out", MEM_R_EN_out, v & h.rd);
    checkOutput("MEM_W_EN_out", MEM_W_EN_out, v & h.wr);
    checkOutput("Dest_out", Dest_out, h.dest);
    checkOutput("Val_Rm_out", Val_Rm_out, h.val);
    checkOutput("ALU_res_out", ALU_res_out, h.alu);
`ifdef EXE_MEM_STALL_CNT_EN
    checkOutput("stall_cycles", stall_cycles, stallM);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1, 1, 0, 0, 4'h1, 32'h0, 32'h0, 0);
    tick();
    tick();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_wb_en", WB_EN_out, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("release_in_ready", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 4'(i), 32'h0, 32'h10 + 32'(4 * i), 1);
      tick();
      checkOutput("stream_alu", ALU_res_out, 32'h10 + 32'(4 * i));
      checkOutput("stream_valid", out_valid, 1);
    end
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("stream_drained", out_valid, 0);

    applyStimulus(1, 0, 0, 1, 4'h0, 32'hDEAD, 32'h40, 0);
    tick();
    applyStimulus(1, 1, 1, 0, 4'h5, 32'h0, 32'h44, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
      checkOutput("stall_store_alu", ALU_res_out, 32'h40);
      checkOutput("stall_store_val", Val_Rm_out, 32'hDEAD);
      checkOutput("stall_store_wen", MEM_W_EN_out, 1);
      checkOutput("stall_full_ready", in_ready, 0);
    end
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("drain_load_alu", ALU_res_out, 32'h44);
    checkOutput("drain_load_ren", MEM_R_EN_out, 1);
    checkOutput("drain_ready", in_ready, 1);
    tick();
    checkOutput("drain_empty", out_valid, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bubble_valid", out_valid, 0);
      checkOutput("bubble_wen", MEM_W_EN_out, 0);
    end

    applyStimulus(1, 0, 0, 1, 4'h3, 32'hBEEF, 32'h80, 0);
    tick();
    applyStimulus(1, 1, 1, 0, 4'h4, 32'h0, 32'h84, 0);
    tick();
    checkOutput("midstall_full", in_ready, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    tick();
    checkOutput("midstall_rst_valid", out_valid, 0);
    checkOutput("midstall_rst_alu", ALU_res_out, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_replay", out_valid, 0);
    end

`ifdef EXE_MEM_STALL_CNT_EN
    applyStimulus(1, 1, 0, 0, 4'h7, 32'h0, 32'h100, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("stall_count_7", stall_cycles, 32'd7);
    rst = 1'b1;
    tick();
    checkOutput("stall_count_rst", stall_cycles, 32'd0);
    rst = 1'b0;
    tick();
`endif

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom, $urandom, ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
